// File: rtl/fan_speed_ctrl.sv
// ---------------------------------------------------------------------------
// fan_speed_ctrl
//
// Thermal fan controller. Latches temperature samples, maps them linearly to
// a target duty-cycle word with on/off hysteresis, kick-starts a stopped fan
// at full speed, then slews the output toward the target at a limited rate.
// Over-temperature forces full speed and raises an alarm.
//
// Ports
//   clk         in   1  clock, rising edge
//   arst        in   1  asynchronous reset, active-low (0 = reset)
//   enable      in   1  1 = control active, 0 = fan off
//   temp        in   8  temperature sample, unsigned degC
//   temp_valid  in   1  capture qualifier for temp
//   speed       out  8  registered duty-cycle word for the PWM stage
//   fan_on      out  1  1 whenever the FSM is not in OFF
//   alarm       out  1  1 while the FSM is in CRIT
//   state       out  3  FSM debug view: OFF=0 START=1 RAMP=2 HOLD=3 CRIT=4
//
// Input qualifier: temp is captured on every rising clk edge where
// temp_valid=1; there is no back-pressure, so a sample is never stalled or
// dropped and the captured value holds until the next valid sample.
// ---------------------------------------------------------------------------
module fan_speed_ctrl #(
    parameter int unsigned T_LOW    = 30,
    parameter int unsigned T_CRIT   = 80,
    parameter int unsigned HYST     = 3,
    parameter int unsigned SPD_MIN  = 64,
    parameter int unsigned GAIN     = 4,
    parameter int unsigned STEP     = 8,
    parameter int unsigned RAMP_DIV = 4,
    parameter int unsigned KICK_CYC = 8
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       enable,
    input  logic [7:0] temp,
    input  logic       temp_valid,
    output logic [7:0] speed,
    output logic       fan_on,
    output logic       alarm,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_START = 3'd1,
        ST_RAMP  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_CRIT  = 3'd4
    } state_t;

    localparam logic [7:0]  LP_T_LOW    = 8'(T_LOW);
    localparam logic [7:0]  LP_T_OFF    = 8'(T_LOW - HYST);
    localparam logic [7:0]  LP_T_CRIT   = 8'(T_CRIT);
    localparam logic [7:0]  LP_T_CRIT_X = 8'(T_CRIT - HYST);
    localparam logic [7:0]  LP_SPD_MIN  = 8'(SPD_MIN);
    localparam logic [7:0]  LP_STEP     = 8'(STEP);
    localparam logic [7:0]  LP_KICK_M1  = 8'(KICK_CYC - 1);
    localparam logic [15:0] LP_DIV_M1   = 16'(RAMP_DIV - 1);

    // Registers
    logic [7:0]  r_temp_q;
    logic        r_on_flag;
    state_t      r_state;
    logic [7:0]  r_speed;
    logic        r_fan_on;
    logic        r_alarm;
    logic [7:0]  r_kick_cnt;
    logic [15:0] r_tick_cnt;

    // Combinational
    logic        w_on_flag;
    logic [15:0] w_lin;
    logic [7:0]  w_target;
    logic        w_tick;
    logic [7:0]  w_up;
    logic [7:0]  w_dn;
    logic [7:0]  w_up_step;
    logic [7:0]  w_dn_step;
    state_t      w_state_nxt;
    logic [7:0]  w_speed_nxt;
    logic [7:0]  w_kick_nxt;
    logic        w_ramp_entry;

    // ------------------------------------------------------------------
    // Sample capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_temp_q <= 8'd0;
        end else if (temp_valid) begin
            r_temp_q <= temp;
        end
    end

    // ------------------------------------------------------------------
    // Hysteresis flag. The effective flag is resolved combinationally from
    // the current sample so the target reacts in the same cycle temp_q
    // changes; the register only remembers the decision inside the band.
    // ------------------------------------------------------------------
    always_comb begin
        w_on_flag = r_on_flag;
        if (r_temp_q >= LP_T_LOW) begin
            w_on_flag = 1'b1;
        end else if (r_temp_q < LP_T_OFF) begin
            w_on_flag = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_on_flag <= 1'b0;
        end else begin
            r_on_flag <= w_on_flag;
        end
    end

    // ------------------------------------------------------------------
    // Target speed: linear above T_LOW, floor of SPD_MIN inside the
    // hysteresis band, saturated at 255. 16-bit math keeps the full
    // 8-bit temperature range from overflowing before the clamp.
    // ------------------------------------------------------------------
    always_comb begin
        w_lin    = 16'(SPD_MIN) + (({8'd0, r_temp_q}) - 16'(T_LOW)) * 16'(GAIN);
        w_target = 8'd0;
        if (!w_on_flag) begin
            w_target = 8'd0;
        end else if (r_temp_q < LP_T_LOW) begin
            w_target = LP_SPD_MIN;
        end else if (w_lin > 16'd255) begin
            w_target = 8'd255;
        end else begin
            w_target = w_lin[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Slew limiting. Each step is bounded by the remaining distance so the
    // output lands exactly on the target and can never wrap.
    // ------------------------------------------------------------------
    always_comb begin
        w_up      = w_target - r_speed;
        w_dn      = r_speed - w_target;
        w_up_step = (w_up > LP_STEP) ? LP_STEP : w_up;
        w_dn_step = (w_dn > LP_STEP) ? LP_STEP : w_dn;
    end

    assign w_tick = (r_tick_cnt == LP_DIV_M1);

    // ------------------------------------------------------------------
    // FSM next-state / next-output
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_speed_nxt = r_speed;
        w_kick_nxt  = r_kick_cnt;

        if (!enable) begin
            w_state_nxt = ST_OFF;
            w_speed_nxt = 8'd0;
        end else if (r_temp_q >= LP_T_CRIT) begin
            w_state_nxt = ST_CRIT;
            w_speed_nxt = 8'd255;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_speed_nxt = 8'd0;
                    if (w_target != 8'd0) begin
                        w_state_nxt = ST_START;
                        w_speed_nxt = 8'd255;
                        w_kick_nxt  = LP_KICK_M1;
                    end
                end
                ST_START: begin
                    w_speed_nxt = 8'd255;
                    if (r_kick_cnt == 8'd0) begin
                        w_state_nxt = ST_RAMP;
                    end else begin
                        w_kick_nxt = r_kick_cnt - 8'd1;
                    end
                end
                ST_RAMP: begin
                    // Exit checks use the registered speed, so HOLD/OFF is
                    // reached one clock after the final step lands.
                    if ((r_speed == w_target) && (w_target != 8'd0)) begin
                        w_state_nxt = ST_HOLD;
                    end else if ((r_speed == 8'd0) && (w_target == 8'd0)) begin
                        w_state_nxt = ST_OFF;
                    end else if (w_tick) begin
                        if (r_speed < w_target) begin
                            w_speed_nxt = r_speed + w_up_step;
                        end else if (r_speed > w_target) begin
                            w_speed_nxt = r_speed - w_dn_step;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_target != r_speed) begin
                        w_state_nxt = ST_RAMP;
                    end
                end
                ST_CRIT: begin
                    w_speed_nxt = 8'd255;
                    if (r_temp_q < LP_T_CRIT_X) begin
                        w_state_nxt = ST_RAMP;
                    end
                end
                default: begin
                    w_state_nxt = ST_OFF;
                    w_speed_nxt = 8'd0;
                end
            endcase
        end
    end

    assign w_ramp_entry = (w_state_nxt == ST_RAMP) && (r_state != ST_RAMP);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_state    <= ST_OFF;
            r_speed    <= 8'd0;
            r_fan_on   <= 1'b0;
            r_alarm    <= 1'b0;
            r_kick_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_speed    <= w_speed_nxt;
            r_fan_on   <= (w_state_nxt != ST_OFF);
            r_alarm    <= (w_state_nxt == ST_CRIT);
            r_kick_cnt <= w_kick_nxt;
        end
    end

    // Free-running ramp prescaler, re-phased on every entry to RAMP so the
    // first step always comes RAMP_DIV clocks after entry.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_tick_cnt <= 16'd0;
        end else if (w_ramp_entry || w_tick) begin
            r_tick_cnt <= 16'd0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 16'd1;
        end
    end

    assign speed  = r_speed;
    assign fan_on = r_fan_on;
    assign alarm  = r_alarm;
    assign state  = r_state;

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fan_speed_ctrl
//
// Self-checking bench for fan_speed_ctrl: directed vector table, hand-timed
// sequences for latency / kick / enable-drop / async reset, and randomized
// traffic checked every clock against a rule-level reference model.
// ---------------------------------------------------------------------------
module tb_fan_speed_ctrl;

    logic       clk;
    logic       arst;
    logic       enable;
    logic [7:0] temp;
    logic       temp_valid;
    logic [7:0] speed;
    logic       fan_on;
    logic       alarm;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    fan_speed_ctrl dut (
        .clk        (clk),
        .arst       (arst),
        .enable     (enable),
        .temp       (temp),
        .temp_valid (temp_valid),
        .speed      (speed),
        .fan_on     (fan_on),
        .alarm      (alarm),
        .state      (state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Mode numbers follow the documented debug encoding of the state output.
    int m_tq, m_on, m_mode, m_spd, m_kick, m_age;

    task automatic model_reset();
        m_tq = 0; m_on = 0; m_mode = 0; m_spd = 0; m_kick = 0; m_age = 0;
    endtask

    task automatic model_step();
        int on_eff, tgt, nmode, nspd, d;
        if (m_tq >= 30)      on_eff = 1;
        else if (m_tq < 27)  on_eff = 0;
        else                 on_eff = m_on;
        if (on_eff == 0)     tgt = 0;
        else if (m_tq < 30)  tgt = 64;
        else                 tgt = 64 + (m_tq - 30) * 4;
        if (tgt > 255) tgt = 255;

        nmode = m_mode;
        nspd  = m_spd;
        if (!enable) begin
            nmode = 0; nspd = 0;
        end else if (m_tq >= 80) begin
            nmode = 4; nspd = 255;
        end else begin
            case (m_mode)
                0: if (tgt != 0) begin nmode = 1; nspd = 255; m_kick = 8 - 1; end
                1: begin
                    nspd = 255;
                    if (m_kick == 0) nmode = 2;
                    else m_kick = m_kick - 1;
                end
                2: begin
                    if (m_spd == tgt && tgt != 0) nmode = 3;
                    else if (m_spd == 0 && tgt == 0) nmode = 0;
                    else if ((m_age % 4) == 3) begin
                        d = tgt - m_spd;
                        if (d > 8)  d = 8;
                        if (d < -8) d = -8;
                        nspd = m_spd + d;
                    end
                end
                3: if (tgt != m_spd) nmode = 2;
                4: if (m_tq < 77) begin nmode = 2; nspd = 255; end
                default: nmode = 0;
            endcase
        end
        // clocks spent in RAMP since entry
        if (nmode == 2) m_age = (m_mode == 2) ? m_age + 1 : 0;
        m_mode = nmode;
        m_spd  = nspd;
        m_on   = on_eff;
        if (temp_valid) m_tq = int'(temp);
    endtask

    task automatic check_model();
        int e_alarm, e_fan;
        e_alarm = (m_mode == 4) ? 1 : 0;
        e_fan   = (m_mode != 0) ? 1 : 0;
        n_tests++;
        if (int'(state) != m_mode || int'(speed) != m_spd ||
            int'(alarm) != e_alarm || int'(fan_on) != e_fan) begin
            n_fail++;
            $display("FAIL model t=%0t: got state=%0d speed=%0d alarm=%0d fan_on=%0d, want state=%0d speed=%0d alarm=%0d fan_on=%0d",
                     $time, state, speed, alarm, fan_on, m_mode, m_spd, e_alarm, e_fan);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s t=%0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    // One clock: model follows the edge while out of reset, outputs sampled 1ns later.
    task automatic cyc();
        @(posedge clk);
        if (arst) model_step();
        #1;
        check_model();
    endtask

    task automatic wait_state(input int s, input int max_cyc);
        int found;
        found = 0;
        for (int i = 0; i < max_cyc && found == 0; i++) begin
            cyc();
            if (int'(state) == s) found = 1;
        end
        chk("wait_state", found, 1);
    endtask

    // Asynchronous reset pulse applied between clock edges (caller sits at posedge+1).
    task automatic async_reset_pulse(input string name);
        #2;
        arst = 1'b0;
        model_reset();
        #1;
        chk({name, "_speed"}, int'(speed), 0);
        chk({name, "_state"}, int'(state), 0);
        chk({name, "_alarm"}, int'(alarm), 0);
        chk({name, "_fan_on"}, int'(fan_on), 0);
        cyc();
        cyc();
        arst = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       en;
        logic [7:0] tmp;
        int         ncyc;
        int         e_state;
        int         e_speed;
        int         e_alarm;
        int         e_fan;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{1'b1, 8'd40,  120, 3, 104, 0, 1};  // settle after kick
        vecs[1]  = '{1'b1, 8'd29,   60, 3,  64, 0, 1};  // hysteresis band keeps fan on
        vecs[2]  = '{1'b1, 8'd26,   60, 0,   0, 0, 0};  // below band -> ramp down -> OFF
        vecs[3]  = '{1'b1, 8'd29,   20, 0,   0, 0, 0};  // band does not restart
        vecs[4]  = '{1'b1, 8'd30,  200, 3,  64, 0, 1};  // T_LOW restarts at SPD_MIN
        vecs[5]  = '{1'b1, 8'd85,    4, 4, 255, 1, 1};  // critical
        vecs[6]  = '{1'b1, 8'd78,   20, 4, 255, 1, 1};  // CRIT hysteresis
        vecs[7]  = '{1'b1, 8'd76,   40, 3, 248, 0, 1};  // CRIT exit
        vecs[8]  = '{1'b1, 8'd79,   20, 3, 255, 0, 1};  // 260 saturates to 255
        vecs[9]  = '{1'b1, 8'd60,   80, 3, 184, 0, 1};  // ramp down to 184
        vecs[10] = '{1'b0, 8'd60,    3, 0,   0, 0, 0};  // enable drop
        vecs[11] = '{1'b1, 8'd100,   5, 4, 255, 1, 1};  // CRIT straight from OFF
        vecs[12] = '{1'b1, 8'd0,   160, 0,   0, 0, 0};  // CRIT -> ramp 255..0 -> OFF
    end

    // ---------------- main sequence ----------------
    initial begin
        int sel;
        arst       = 1'b0;
        enable     = 1'b0;
        temp       = 8'd0;
        temp_valid = 1'b0;
        model_reset();

        // reset state
        #2;
        chk("rst_state",  int'(state),  0);
        chk("rst_speed",  int'(speed),  0);
        chk("rst_alarm",  int'(alarm),  0);
        chk("rst_fan_on", int'(fan_on), 0);
        @(posedge clk);
        #1;
        arst   = 1'b1;
        enable = 1'b1;
        repeat (3) cyc();
        chk("idle_off", int'(state), 0);

        // kick timing: sample edge, START next edge, 8 clocks at 255, first step 4 clocks into RAMP
        temp = 8'd40; temp_valid = 1'b1;
        cyc();
        temp_valid = 1'b0;
        chk("kick_sample_edge", int'(state), 0);
        cyc();
        chk("kick_start",       int'(state), 1);
        chk("kick_speed",       int'(speed), 255);
        for (int i = 0; i < 7; i++) begin
            cyc();
            chk("kick_hold", int'(state), 1);
        end
        cyc();
        chk("kick_to_ramp",     int'(state), 2);
        chk("kick_ramp_speed",  int'(speed), 255);
        repeat (3) cyc();
        chk("ramp_pre_tick",    int'(speed), 255);
        cyc();
        chk("ramp_first_step",  int'(speed), 247);

        // directed table
        for (int v = 0; v < 13; v++) begin
            enable = vecs[v].en; temp = vecs[v].tmp; temp_valid = 1'b1;
            repeat (vecs[v].ncyc) cyc();
            chk($sformatf("vec%0d_state",  v), int'(state),  vecs[v].e_state);
            chk($sformatf("vec%0d_speed",  v), int'(speed),  vecs[v].e_speed);
            chk($sformatf("vec%0d_alarm",  v), int'(alarm),  vecs[v].e_alarm);
            chk($sformatf("vec%0d_fan_on", v), int'(fan_on), vecs[v].e_fan);
        end
        temp_valid = 1'b0;

        // CRIT latency: two clocks after the sample edge
        enable = 1'b1; temp = 8'd85; temp_valid = 1'b1;
        cyc();
        temp_valid = 1'b0;
        chk("crit_lat_edge1", int'(state), 0);
        cyc();
        chk("crit_lat_state", int'(state), 4);
        chk("crit_lat_speed", int'(speed), 255);
        chk("crit_lat_alarm", int'(alarm), 1);
        temp = 8'd0; temp_valid = 1'b1;
        wait_state(0, 200);
        temp_valid = 1'b0;

        // enable drop during START cycle 3
        temp = 8'd50; temp_valid = 1'b1;
        cyc();
        temp_valid = 1'b0;
        cyc();
        chk("edrop_start", int'(state), 1);
        cyc();
        cyc();
        enable = 1'b0;
        cyc();
        chk("edrop_state",  int'(state),  0);
        chk("edrop_speed",  int'(speed),  0);
        chk("edrop_fan_on", int'(fan_on), 0);

        // async reset mid-RAMP
        enable = 1'b1;
        wait_state(2, 40);
        repeat (5) cyc();
        chk("pre_rst_ramp", int'(state), 2);
        async_reset_pulse("arst_mid");
        repeat (10) cyc();
        chk("post_rst_state", int'(state), 0);
        chk("post_rst_speed", int'(speed), 0);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                async_reset_pulse("arst_rand");
            end
            if ($urandom_range(0, 15) == 0) enable = ($urandom_range(0, 9) != 0);
            temp_valid = ($urandom_range(0, 7) == 0);
            sel = $urandom_range(0, 3);
            case (sel)
                0:       temp = 8'($urandom_range(0, 35));
                1:       temp = 8'($urandom_range(25, 90));
                2:       temp = 8'($urandom_range(70, 90));
                default: temp = 8'($urandom_range(0, 255));
            endcase
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // global time bound
    initial begin
        #400000;
        $display("FAIL timeout t=%0t: got no completion, want completion", $time);
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
